riscv_mc_datapath_hs: RTL and testbench
=======================================

Name: riscv_mc_datapath_hs

Overview:
Parametrised next-generation multicycle RISC-V datapath: PC/OldPC/IR/MDR/A/B/ALUOut registers, register file, immediate extender, ALU and operand/result muxes, generalised to XLEN and register count. The zero-latency internal memory is replaced by an external request/ready memory port, sequenced by an internal access FSM that stalls the controller. It sits between the multicycle controller and the shared instruction/data memory.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
NREG, 32, architectural register count; power of 2, 2..32; address width is log2(NREG).
RESET_PC, 0, PC value loaded on reset; XLEN bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
pc_write  input  1  PC <= Result this edge
adr_src  input  1  memory address select: 0=PC, 1=Result
mem_access  input  1  controller requests one memory transaction
mem_write  input  1  transaction is a store; sampled with mem_access
ir_write  input  1  load IR/OldPC when a transaction completes
reg_write  input  1  register file write of Result to rd
result_src  input  2  0=ALUOut, 1=MDR, 2=ALUResult, 3=ImmExt
alu_src_a  input  2  0=PC, 1=OldPC, 2=A, 3=0
alu_src_b  input  2  0=B, 1=ImmExt, 2=4, 3=0
alu_control  input  3  ALU operation
imm_src  input  3  0=I, 1=S, 2=B, 3=U, 4=J; other codes give 0
mem_req  output  1  memory request valid
mem_we  output  1  store strobe, valid while mem_req=1
mem_addr  output  XLEN  transaction address
mem_wdata  output  XLEN  store data
mem_rdata  input  XLEN  read data, valid when mem_ready=1
mem_ready  input  1  memory completes the transaction
mem_done  output  1  one-cycle pulse: transaction finished
op  output  7  IR[6:0]
func3  output  3  IR[14:12]
func7  output  1  IR[30]
zero  output  1  ALUResult == 0
neg  output  1  ALUResult[XLEN-1]
stall_cnt  output  32  memory wait-cycle counter (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC; OldPC, IR, MDR, A, B, ALUOut and all registers = 0; FSM=IDLE; mem_req=0, mem_we=0, mem_done=0, stall_cnt=0. If reset arrives mid-transaction, the transaction is abandoned with no MDR/IR update.
- A, B and ALUOut load every edge from RD1, RD2 and ALUResult. PC loads Result when pc_write=1. Register writes occur on the edge when reg_write=1. Writes to x0 are ignored and x0 reads return 0. Register addresses use IR fields truncated to log2(NREG) bits.
- Immediates are sign-extended to XLEN from IR[31]. U-type is IR[31:12]<<12, sign-extended.
- ALU: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed), 101 xor, 110 sltu, 111 srl by rhs[log2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN. slt/sltu return 1 or 0 zero-extended.
- Access FSM states: IDLE, BUSY, DONE.
  - IDLE: if mem_access=1 at an edge, capture address (adr_src mux), B as wdata and mem_write into holding registers, then go to BUSY.
  - BUSY: mem_req=1. mem_addr, mem_wdata and mem_we come from the holding registers and stay stable until mem_ready. On the edge with mem_ready=1: MDR <= mem_rdata; if ir_write=1, also IR <= mem_rdata and OldPC <= PC. Then go to DONE.
  - DONE: mem_done=1 for exactly one cycle, then IDLE. mem_access is ignored in DONE. A back-to-back request must be re-asserted in IDLE.
- Minimum latency: mem_access sampled at edge T, mem_req high after T, mem_ready=1 at T+1, mem_done high between T+2 and T+3. Total 3 cycles from request to pulse.
- For stores, MDR still captures mem_rdata (don't-care data). IR is only written when ir_write=1.
- mem_req outside BUSY is 0. mem_ready outside BUSY is ignored.

Optional Feature:
DP_STALL_CNT_EN:
- Defined: stall_cnt increments by 1 on every BUSY cycle with mem_ready=0. It saturates at 2^32-1 and clears only on reset.
- Undefined: stall_cnt is constant 0 and no counter logic is synthesised.

Test Plan:
- Reset with RESET_PC=0x100 -> PC=0x100, mem_req=0, mem_done=0, IR=0 after release.
- Fetch with adr_src=0, mem_access=1, ir_write=1, memory returns 0x00500093 with 2 wait cycles -> mem_addr=0x100 held, mem_done pulses once, IR=0x00500093, OldPC=0x100, op=0x13, stall_cnt=2 with feature defined.
- Store with A=0x40, imm=8, B=0xDEADBEEF, adr_src=1, mem_write=1 -> mem_addr=0x48, mem_wdata=0xDEADBEEF, mem_we=1 only while mem_req=1.
- XLEN=64, sub of 0 - 1 -> ALUResult=0xFFFF_FFFF_FFFF_FFFF, neg=1, zero=0. slt(-1,1)=1; sltu(-1,1)=0.
- reg_write to x0 with Result=5, then read rs1=x0 -> RD1=0. NREG=16: rd=x17 aliases to x1.
- Assert reset while in BUSY -> mem_req drops immediately, MDR/IR unchanged at 0, FSM=IDLE, no mem_done pulse.

Source files
------------

// File: rtl/riscv_mc_datapath_hs_if.sv
// riscv_mc_datapath_hs_if: request/ready memory port between datapath (master) and memory (slave)
interface riscv_mc_datapath_hs_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/riscv_mc_datapath_hs.sv
// riscv_mc_datapath_hs: multicycle RISC-V datapath with handshaked memory access FSM
// DP_STALL_CNT_EN adds a saturating memory wait-cycle counter on stall_cnt
module riscv_mc_datapath_hs #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        adr_src,
  input  logic        mem_access,
  input  logic        mem_write,
  input  logic        ir_write,
  input  logic        reg_write,
  input  logic [1:0]  result_src,
  input  logic [1:0]  alu_src_a,
  input  logic [1:0]  alu_src_b,
  input  logic [2:0]  alu_control,
  input  logic [2:0]  imm_src,
  riscv_mc_datapath_hs_if.master mem,
  output logic        mem_done,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7,
  output logic        zero,
  output logic        neg,
  output logic [31:0] stall_cnt
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, mdr_q, mdr_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [XLEN-1:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic            hwe_q, hwe_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
  logic            busy, fire;
  assign rs1 = ir_q[15 +: AW];
  assign rs2 = ir_q[20 +: AW];
  assign rd  = ir_q[7 +: AW];
  assign rd1 = rs1 == '0 ? '0 : rf_q[rs1];
  assign rd2 = rs2 == '0 ? '0 : rf_q[rs2];
  assign op    = ir_q[6:0];
  assign func3 = ir_q[14:12];
  assign func7 = ir_q[30];
  always_comb begin
    case (imm_src)
      3'd0:    imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      3'd1:    imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2:    imm_ext = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3:    imm_ext = {{(XLEN-31){ir_q[31]}}, ir_q[30:12], 12'b0};
      3'd4:    imm_ext = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end
  assign src_a = alu_src_a == 2'd0 ? pc_q : alu_src_a == 2'd1 ? oldpc_q : alu_src_a == 2'd2 ? a_q : '0;
  assign src_b = alu_src_b == 2'd0 ? b_q : alu_src_b == 2'd1 ? imm_ext :
                 alu_src_b == 2'd2 ? XLEN'(4) : '0;
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'b101:  alu_result = src_a ^ src_b;
      3'b110:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: alu_result = src_a >> src_b[SW-1:0];
    endcase
  end
  assign zero = alu_result == '0;
  assign neg  = alu_result[XLEN-1];
  assign result = result_src == 2'd0 ? aluout_q : result_src == 2'd1 ? mdr_q :
                  result_src == 2'd2 ? alu_result : imm_ext;
  assign busy = state_q == BUSY;
  assign fire = busy && mem.mem_ready;
  always_comb begin
    state_d  = state_q == IDLE ? (mem_access ? BUSY : IDLE) : busy ? (mem.mem_ready ? DONE : BUSY) : IDLE;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwe_d    = hwe_q;
    if (state_q == IDLE && mem_access) begin
      haddr_d  = adr_src ? result : pc_q;
      hwdata_d = b_q;
      hwe_d    = mem_write;
    end
    pc_d     = pc_write ? result : pc_q;
    mdr_d    = fire ? mem.mem_rdata : mdr_q;
    ir_d     = fire && ir_write ? mem.mem_rdata[31:0] : ir_q;
    oldpc_d  = fire && ir_write ? pc_q : oldpc_q;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = alu_result;
    rf_d     = rf_q;
    if (reg_write && rd != '0) rf_d[rd] = result;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      {oldpc_q, mdr_q, a_q, b_q, aluout_q, haddr_q, hwdata_q} <= '0;
      ir_q    <= '0;
      hwe_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      mdr_q    <= mdr_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwe_q    <= hwe_d;
      rf_q     <= rf_d;
    end
  end
  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && hwe_q;
  assign mem.mem_addr  = haddr_q;
  assign mem.mem_wdata = hwdata_q;
  assign mem_done      = state_q == DONE;
`ifdef DP_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = busy && !mem.mem_ready && stall_q != '1 ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_mc_datapath_hs.sv
// tb_riscv_mc_datapath_hs: scoreboard bench for the handshaked multicycle datapath (32-bit and 64-bit/16-reg builds)
module tb_riscv_mc_datapath_hs;
  typedef struct packed {
    logic pc_write, adr_src, mem_access, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
  } ctl_t;
  typedef struct packed {
    logic [31:0] addr, wdata;
    logic        we;
  } exp_t;
`ifdef DP_STALL_CNT_EN
  localparam int EXP_STALL = 2;
`else
  localparam int EXP_STALL = 0;
`endif
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  ctl_t c, d;
  logic done32, f7_32, zero32, neg32, done64, f7_64, zero64, neg64;
  logic [6:0] op32, op64;
  logic [2:0] f3_32, f3_64;
  logic [31:0] sc32, sc64;
  int errors = 0, checks = 0;
  exp_t sbq[$];
  riscv_mc_datapath_hs_if #(.XLEN(32)) m32();
  riscv_mc_datapath_hs_if #(.XLEN(64)) m64();
  riscv_mc_datapath_hs #(.XLEN(32), .NREG(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .pc_write(c.pc_write), .adr_src(c.adr_src), .mem_access(c.mem_access),
    .mem_write(c.mem_write), .ir_write(c.ir_write), .reg_write(c.reg_write), .result_src(c.result_src),
    .alu_src_a(c.alu_src_a), .alu_src_b(c.alu_src_b), .alu_control(c.alu_control), .imm_src(c.imm_src),
    .mem(m32), .mem_done(done32), .op(op32), .func3(f3_32), .func7(f7_32), .zero(zero32), .neg(neg32),
    .stall_cnt(sc32));
  riscv_mc_datapath_hs #(.XLEN(64), .NREG(16), .RESET_PC(64'h0)) dut64 (
    .clk(clk), .rst(rst), .pc_write(d.pc_write), .adr_src(d.adr_src), .mem_access(d.mem_access),
    .mem_write(d.mem_write), .ir_write(d.ir_write), .reg_write(d.reg_write), .result_src(d.result_src),
    .alu_src_a(d.alu_src_a), .alu_src_b(d.alu_src_b), .alu_control(d.alu_control), .imm_src(d.imm_src),
    .mem(m64), .mem_done(done64), .op(op64), .func3(f3_64), .func7(f7_64), .zero(zero64), .neg(neg64),
    .stall_cnt(sc64));

  task automatic access32(input int waits, input logic [31:0] rdata, output exp_t o, output logic held,
                          output int dones);
    c.mem_access = 1;
    @(negedge clk);
    c.mem_access = 0;
    o = '{addr: m32.mem_addr, wdata: m32.mem_wdata, we: m32.mem_we};
    held = m32.mem_req;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (!(m32.mem_req && m32.mem_addr == o.addr && m32.mem_wdata == o.wdata && m32.mem_we == o.we)) held = 0;
    end
    m32.mem_ready = 1;
    m32.mem_rdata = rdata;
    @(negedge clk);
    m32.mem_ready = 0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      dones += int'(done32);
      @(negedge clk);
    end
  endtask

  task automatic load_ir(input logic [31:0] instr);
    exp_t o;
    logic h;
    int n;
    c.adr_src = 0;
    c.mem_write = 0;
    c.ir_write = 1;
    access32(0, instr, o, h, n);
    c.ir_write = 0;
  endtask

  task automatic exec(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] rs,
                      input logic regw, input logic pcw);
    c.alu_src_a = sa;
    c.alu_src_b = sb;
    c.alu_control = alu;
    c.result_src = rs;
    c.reg_write = regw;
    c.pc_write = pcw;
    @(negedge clk);
    c.reg_write = 0;
    c.pc_write = 0;
    @(negedge clk);
  endtask

  task automatic load_ir64(input logic [31:0] instr);
    d.ir_write = 1;
    d.mem_access = 1;
    @(negedge clk);
    d.mem_access = 0;
    m64.mem_ready = 1;
    m64.mem_rdata = {32'h0, instr};
    @(negedge clk);
    m64.mem_ready = 0;
    d.ir_write = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 0;
    #1;
    checks++; if (dut.pc_q !== 32'h100) begin errors++; $display("FAIL reset_async_pc: got %h want 100", dut.pc_q); end
    checks++; if (m32.mem_req !== 1'b0) begin errors++; $display("FAIL reset_async_req: got %b want 0", m32.mem_req); end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (dut.pc_q !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want 100", dut.pc_q); end
    checks++; if (dut.ir_q !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", dut.ir_q); end
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done32); end
    checks++; if (sc32 !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", sc32); end
    checks++; if (dut64.pc_q !== 64'h0) begin errors++; $display("FAIL reset_pc64: got %h want 0", dut64.pc_q); end
  endtask

  task automatic test_fetch;
    exp_t o, e;
    logic h;
    int n;
    c.adr_src = 0;
    c.ir_write = 1;
    sbq.push_back('{addr: 32'h100, wdata: 32'h0, we: 1'b0});
    access32(2, 32'h00500093, o, h, n);
    c.ir_write = 0;
    e = sbq.pop_front();
    checks++; if (o !== e) begin errors++; $display("FAIL fetch_bus: got %h want %h", o, e); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL fetch_hold: got %b want 1", h); end
    checks++; if (n != 1) begin errors++; $display("FAIL fetch_done_pulses: got %0d want 1", n); end
    checks++; if (dut.ir_q !== 32'h00500093) begin errors++; $display("FAIL fetch_ir: got %h want 00500093", dut.ir_q); end
    checks++; if (dut.oldpc_q !== 32'h100) begin errors++; $display("FAIL fetch_oldpc: got %h want 100", dut.oldpc_q); end
    checks++; if (op32 !== 7'h13) begin errors++; $display("FAIL fetch_op: got %h want 13", op32); end
    checks++; if (sc32 !== 32'(EXP_STALL)) begin errors++; $display("FAIL fetch_stall: got %0d want %0d", sc32, EXP_STALL); end
  endtask

  task automatic test_x0;
    load_ir(32'h00500013);
    c.imm_src = 3'd0;
    exec(2'd3, 2'd3, 3'd0, 2'd3, 1'b1, 1'b0);
    checks++; if (dut.rd1 !== 32'h0) begin errors++; $display("FAIL x0_rd1: got %h want 0", dut.rd1); end
    checks++; if (dut.a_q !== 32'h0) begin errors++; $display("FAIL x0_a: got %h want 0", dut.a_q); end
  endtask

  task automatic test_store;
    exp_t o, e;
    logic h;
    int n;
    c.imm_src = 3'd3;
    load_ir(32'hDEADC1B7);
    exec(2'd3, 2'd3, 3'd0, 2'd3, 1'b1, 1'b0);
    c.imm_src = 3'd0;
    load_ir(32'hEEF18193);
    exec(2'd2, 2'd1, 3'd0, 2'd2, 1'b1, 1'b0);
    checks++; if (dut.rf_q[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_x3: got %h want deadbeef", dut.rf_q[3]); end
    load_ir(32'h04000113);
    exec(2'd3, 2'd1, 3'd0, 2'd2, 1'b1, 1'b0);
    load_ir(32'h00312423);
    c.imm_src = 3'd1;
    c.alu_src_a = 2'd2;
    c.alu_src_b = 2'd1;
    c.alu_control = 3'd0;
    c.result_src = 2'd2;
    c.adr_src = 1;
    c.mem_write = 1;
    sbq.push_back('{addr: 32'h48, wdata: 32'hDEADBEEF, we: 1'b1});
    access32(1, 32'h12345678, o, h, n);
    c.mem_write = 0;
    c.adr_src = 0;
    e = sbq.pop_front();
    checks++; if (o !== e) begin errors++; $display("FAIL store_bus: got %h want %h", o, e); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL store_hold: got %b want 1", h); end
    checks++; if (m32.mem_we !== 1'b0) begin errors++; $display("FAIL store_we_idle: got %b want 0", m32.mem_we); end
    checks++; if (dut.ir_q !== 32'h00312423) begin errors++; $display("FAIL store_ir_kept: got %h want 00312423", dut.ir_q); end
    checks++; if (dut.mdr_q !== 32'h12345678) begin errors++; $display("FAIL store_mdr: got %h want 12345678", dut.mdr_q); end
  endtask

  task automatic test_back_to_back;
    exp_t o, e;
    logic h;
    int n;
    c.imm_src = 3'd0;
    exec(2'd0, 2'd2, 3'd0, 2'd2, 1'b0, 1'b1);
    checks++; if (dut.pc_q !== 32'h104) begin errors++; $display("FAIL b2b_pc: got %h want 104", dut.pc_q); end
    sbq.push_back('{addr: 32'h104, wdata: 32'hDEADBEEF, we: 1'b0});
    sbq.push_back('{addr: 32'h104, wdata: 32'h0, we: 1'b0});
    c.ir_write = 1;
    for (int k = 0; k < 2; k++) begin
      access32(k, k == 0 ? 32'h00000013 : 32'h40B50533, o, h, n);
      e = sbq.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_bus%0d: got %h want %h", k, o, e); end
      checks++; if (n != 1) begin errors++; $display("FAIL b2b_done%0d: got %0d want 1", k, n); end
    end
    c.ir_write = 0;
    checks++; if (dut.oldpc_q !== 32'h104) begin errors++; $display("FAIL b2b_oldpc: got %h want 104", dut.oldpc_q); end
    checks++; if ({f7_32, f3_32, op32} !== {1'b1, 3'd0, 7'h33}) begin errors++; $display("FAIL b2b_fields: got %b %h %h want 1 0 33", f7_32, f3_32, op32); end
  endtask

  task automatic test_done_ignore;
    c.mem_access = 1;
    @(negedge clk);
    c.mem_access = 0;
    m32.mem_ready = 1;
    @(negedge clk);
    m32.mem_ready = 0;
    c.mem_access = 1;
    checks++; if (done32 !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", done32); end
    @(negedge clk);
    c.mem_access = 0;
    checks++; if (m32.mem_req !== 1'b0 || done32 !== 1'b0) begin errors++; $display("FAIL done_ignore: got req=%b done=%b want 0 0", m32.mem_req, done32); end
    @(negedge clk);
    checks++; if (m32.mem_req !== 1'b0) begin errors++; $display("FAIL done_no_restart: got %b want 0", m32.mem_req); end
  endtask

  task automatic test_alu64;
    load_ir64(32'h00108893);
    checks++; if (op64 !== 7'h13) begin errors++; $display("FAIL alu64_op: got %h want 13", op64); end
    d.imm_src = 3'd0;
    d.alu_src_a = 2'd3;
    d.alu_src_b = 2'd1;
    d.alu_control = 3'b001;
    #1;
    checks++; if (dut64.alu_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL alu64_sub: got %h want ffffffffffffffff", dut64.alu_result); end
    checks++; if (neg64 !== 1'b1 || zero64 !== 1'b0) begin errors++; $display("FAIL alu64_flags: got neg=%b zero=%b want 1 0", neg64, zero64); end
    d.result_src = 2'd2;
    d.reg_write = 1;
    @(negedge clk);
    d.reg_write = 0;
    @(negedge clk);
    checks++; if (dut64.rf_q[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL alias_x17: got %h want all ones", dut64.rf_q[1]); end
    checks++; if (dut64.a_q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL alias_a: got %h want all ones", dut64.a_q); end
    d.alu_src_a = 2'd2;
    d.alu_control = 3'b100;
    #1;
    checks++; if (dut64.alu_result !== 64'd1) begin errors++; $display("FAIL alu64_slt: got %h want 1", dut64.alu_result); end
    d.alu_control = 3'b110;
    #1;
    checks++; if (dut64.alu_result !== 64'd0 || zero64 !== 1'b1) begin errors++; $display("FAIL alu64_sltu: got %h z=%b want 0 1", dut64.alu_result, zero64); end
    d.alu_control = 3'b000;
    #1;
    checks++; if (dut64.alu_result !== 64'd0) begin errors++; $display("FAIL alu64_wrap: got %h want 0", dut64.alu_result); end
    d.alu_control = 3'b111;
    #1;
    checks++; if (dut64.alu_result !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL alu64_srl: got %h want 7fffffffffffffff", dut64.alu_result); end
  endtask

  task automatic test_reset_busy;
    int n = 0;
    c.mem_access = 1;
    @(negedge clk);
    c.mem_access = 0;
    @(negedge clk);
    checks++; if (m32.mem_req !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b want 1", m32.mem_req); end
    #2 rst = 0;
    #1;
    checks++; if (m32.mem_req !== 1'b0) begin errors++; $display("FAIL rb_req_drop: got %b want 0", m32.mem_req); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rb_state: got %0d want 0", dut.state_q); end
    m32.mem_ready = 1;
    m32.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      n += int'(done32);
      @(negedge clk);
    end
    m32.mem_ready = 0;
    checks++; if (n != 0) begin errors++; $display("FAIL rb_no_done: got %0d want 0", n); end
    checks++; if (dut.mdr_q !== 32'h0 || dut.ir_q !== 32'h0) begin errors++; $display("FAIL rb_mdr_ir: got %h %h want 0 0", dut.mdr_q, dut.ir_q); end
    checks++; if (sc32 !== 32'd0) begin errors++; $display("FAIL rb_stall: got %0d want 0", sc32); end
  endtask

  initial begin
    c = '0;
    d = '0;
    m32.mem_ready = 0;
    m32.mem_rdata = '0;
    m64.mem_ready = 0;
    m64.mem_rdata = '0;
    test_reset;
    test_fetch;
    test_x0;
    test_store;
    test_back_to_back;
    test_done_ignore;
    test_alu64;
    test_reset_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
